// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address sequencer with stall, pending redirect and misaligned-target trap.
// Optional macro PC_TRACE_EN adds the 32-bit trace_count output (RUN cycles without stall).
module pc_sequencer #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter logic [63:0] TRAP_VECTOR = 64'h100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] PCOut,
  output logic        pc_valid,
  output logic        trap
`ifdef PC_TRACE_EN
  ,
  output logic [31:0] trace_count
`endif
);
  typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;
  state_t      r_state, w_next;
  logic [63:0] r_pc, r_pend_t, w_target;
  logic        r_pend_v, w_go, w_redirect, w_misaligned;
  assign w_go         = r_state == RUN && !stall;
  assign w_target     = branch_taken ? branch_target : r_pend_t;
  assign w_redirect   = w_go && (branch_taken || r_pend_v);
  assign w_misaligned = w_redirect && |w_target[1:0];
  assign PCOut        = r_pc;
  // State register; reset returns to BOOT at once, without waiting for a clock.
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= BOOT;
    else      r_state <= w_next;
  // BOOT and TRAP last one cycle; RUN leaves only on a misaligned redirect.
  always_comb w_next = (r_state == RUN && w_misaligned) ? TRAP : RUN;
  // Moore outputs: fetch is valid only in RUN, trap marks the single TRAP cycle.
  always_comb begin
    pc_valid = r_state == RUN;
    trap     = r_state == TRAP;
  end
  // PC update: leaving BOOT/TRAP steps past the held address; RUN redirects or increments.
  always_ff @(posedge clk or negedge rst)
    if (!rst)                r_pc <= RESET_PC;
    else if (r_state != RUN) r_pc <= r_pc + 64'd4;
    else if (w_misaligned)   r_pc <= TRAP_VECTOR;
    else if (w_redirect)     r_pc <= w_target;
    else if (!stall)         r_pc <= r_pc + 64'd4;
  // Redirects that arrive under stall are parked here; the newest wins, any unstalled RUN cycle consumes it.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_pend_v <= 1'b0;
      r_pend_t <= '0;
    end else if (r_state == RUN) begin
      if (stall && branch_taken) begin
        r_pend_v <= 1'b1;
        r_pend_t <= branch_target;
      end else if (!stall) r_pend_v <= 1'b0;
    end
`ifdef PC_TRACE_EN
  logic [31:0] r_trace;
  // Count every RUN cycle that is not stalled; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst)
    if (!rst)      r_trace <= '0;
    else if (w_go) r_trace <= r_trace + 32'd1;
  assign trace_count = r_trace;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table, async-reset sequence and randomized run against a reference model.
module tb_pc_sequencer;
  localparam logic [63:0] TV = 64'h100;
  localparam int S_BOOT = 0, S_RUN = 1, S_TRAP = 2;
  logic        clk = 0, rst = 0, stall = 0, branch_taken = 0;
  logic [63:0] branch_target = '0;
  logic [63:0] PCOut;
  logic        pc_valid, trap;
`ifdef PC_TRACE_EN
  logic [31:0] trace_count;
`endif
  int n_pass = 0, n_chk = 0;

  pc_sequencer #(.RESET_PC(64'h0), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .PCOut(PCOut), .pc_valid(pc_valid), .trap(trap)
`ifdef PC_TRACE_EN
    , .trace_count(trace_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic check_out(input string tag, input logic [63:0] pc, input bit v, input bit tr);
    check({tag, ".pc"}, PCOut, pc);
    check({tag, ".valid"}, {63'd0, pc_valid}, {63'd0, v});
    check({tag, ".trap"}, {63'd0, trap}, {63'd0, tr});
  endtask

  typedef struct {
    bit          s;
    bit          b;
    logic [63:0] t;
    logic [63:0] pc;
    bit          v;
    bit          tr;
  } vec_t;
  vec_t tv[$];

  task automatic add(input bit s, input bit b, input logic [63:0] t, input logic [63:0] pc, input bit v, input bit tr);
    vec_t e;
    e.s = s; e.b = b; e.t = t; e.pc = pc; e.v = v; e.tr = tr;
    tv.push_back(e);
  endtask

  // Reference model: abstract phase, PC, and a 0/1-entry pending queue.
  int          m_state;
  logic [63:0] m_pc;
  logic [63:0] m_pend[$];
  logic [31:0] m_trace;

  task automatic model_reset();
    m_state = S_BOOT; m_pc = 64'h0; m_pend.delete(); m_trace = 0;
  endtask

  task automatic model_edge(input bit s, input bit b, input logic [63:0] t);
    logic [63:0] dest;
    if (m_state != S_RUN) begin
      m_pc = m_pc + 4;
      m_state = S_RUN;
    end else if (s) begin
      if (b) begin m_pend.delete(); m_pend.push_back(t); end
    end else begin
      m_trace++;
      if (b || m_pend.size() > 0) begin
        dest = b ? t : m_pend[0];
        m_pend.delete();
        if (dest % 4 != 0) begin m_pc = TV; m_state = S_TRAP; end
        else m_pc = dest;
      end else m_pc = m_pc + 4;
    end
  endtask

  initial begin
    add(0,0,0,64'h4,1,0); add(0,0,0,64'h8,1,0); add(0,0,0,64'hC,1,0); add(0,0,0,64'h10,1,0);
    add(0,1,64'h200,64'h200,1,0); add(0,0,0,64'h204,1,0);
    add(1,1,64'h300,64'h204,1,0); add(1,1,64'h400,64'h204,1,0); add(1,0,0,64'h204,1,0);
    add(0,0,0,64'h400,1,0); add(0,0,0,64'h404,1,0);
    add(0,1,64'h202,64'h100,0,1); add(1,0,0,64'h104,1,0);
    add(1,1,64'h503,64'h104,1,0); add(0,0,0,64'h100,0,1); add(0,0,0,64'h104,1,0);
    add(1,1,64'h600,64'h104,1,0); add(0,1,64'h700,64'h700,1,0); add(0,0,0,64'h704,1,0);
    add(0,1,64'h1,64'h100,0,1); add(0,1,64'h800,64'h104,1,0); add(0,0,0,64'h108,1,0);
    add(0,1,64'hFFFF_FFFF_FFFF_FFFC,64'hFFFF_FFFF_FFFF_FFFC,1,0); add(0,0,0,64'h0,1,0); add(0,0,0,64'h4,1,0);

    repeat (2) @(negedge clk);
    check_out("reset", 64'h0, 0, 0);
    rst = 1;
    #1 check_out("boot", 64'h0, 0, 0);
    foreach (tv[i]) begin
      stall = tv[i].s; branch_taken = tv[i].b; branch_target = tv[i].t;
      @(negedge clk);
      check_out($sformatf("vec%0d", i), tv[i].pc, tv[i].v, tv[i].tr);
    end

    stall = 1; branch_taken = 1; branch_target = 64'h900;
    @(posedge clk);
    #2 rst = 0;
    #1 check_out("async_rst", 64'h0, 0, 0);
    stall = 0; branch_taken = 0;
    @(negedge clk);
    check_out("held_rst", 64'h0, 0, 0);
    #2 rst = 1;
    #1 check_out("rel_boot", 64'h0, 0, 0);
    @(negedge clk);
    check_out("rel_run1", 64'h4, 1, 0);
    @(negedge clk);
    check_out("rel_run2", 64'h8, 1, 0);

    @(negedge clk);
    rst = 0;
    #1 model_reset();
    rst = 1;
    for (int i = 0; i < 400; i++) begin
      logic [63:0] t;
      t = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 5) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | (t & 64'hC);
      if ($urandom_range(0, 7) == 0) t = t | 64'($urandom_range(1, 3));
      stall = $urandom_range(0, 9) < 3;
      branch_taken = $urandom_range(0, 3) == 0;
      branch_target = t;
      model_edge(stall, branch_taken, t);
      @(negedge clk);
      check_out($sformatf("rnd%0d", i), m_pc, m_state == S_RUN, m_state == S_TRAP);
`ifdef PC_TRACE_EN
      check($sformatf("rnd%0d.trace", i), {32'd0, trace_count}, {32'd0, m_trace});
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
